// File: rtl/mips_fetch_pkg.sv
// Shared MIPS front-end constants and types.
// Used by the fetch and decode stages.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    CT_FALL   = 2'b00,
    CT_BRANCH = 2'b01,
    CT_JUMP   = 2'b10,
    CT_JR     = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_HOLD = 2'b01,
    S_HALT = 2'b10
  } fetch_state_e;

  function automatic logic [31:0] branch_offset(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Next-pc selection for the fetch stage.
// Flags jump-register targets that are not word aligned.
module mips_next_pc
  import mips_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  control_type,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  input  logic [31:0] jr_data,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] w_pc4;

  assign w_pc4 = pc + 32'd4;

  always_comb begin
    next_pc    = w_pc4;
    misaligned = 1'b0;
    unique case (ctrl_e'(control_type))
      CT_FALL:   next_pc = w_pc4;
      CT_BRANCH: next_pc = w_pc4 + branch_offset(imm16);
      CT_JUMP:   next_pc = {w_pc4[31:28], jtarget, 2'b00};
      CT_JR: begin
        next_pc    = jr_data;
        misaligned = |jr_data[1:0];
      end
    endcase
  end

endmodule

// File: rtl/mips_fetch.sv
// MIPS fetch stage: one outstanding imem read,
// instruction buffer toward decode, halt on bad jr.
module mips_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [1:0]  control_type,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  input  logic [31:0] jr_data,
  output logic        fetch_except,
  output logic [31:0] inst_count
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic [31:0] r_count;
  logic        r_except;

  logic [31:0] w_next_pc;
  logic        w_misaligned;
  logic        w_capture;
  logic        w_fire;

  mips_next_pc u_next_pc (
    .pc           (r_pc),
    .control_type (control_type),
    .imm16        (imm16),
    .jtarget      (jtarget),
    .jr_data      (jr_data),
    .next_pc      (w_next_pc),
    .misaligned   (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    inst_valid  = 1'b0;
    w_capture   = 1'b0;
    w_fire      = 1'b0;
    unique case (r_state)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          w_fire      = 1'b1;
          w_state_nxt = w_misaligned ? S_HALT : S_REQ;
        end
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_REQ;
    endcase
  end

  // A misaligned jr is still counted but leaves pc untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_count   <= '0;
      r_except  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_inst    <= imem_rdata;
        r_inst_pc <= r_pc;
      end
      if (w_fire) begin
        r_count <= r_count + 32'd1;
        if (w_misaligned) r_except <= 1'b1;
        else              r_pc     <= w_next_pc;
      end
    end
  end

  assign imem_addr    = r_pc;
  assign inst         = r_inst;
  assign inst_pc      = r_inst_pc;
  assign inst_count   = r_count;
  assign fetch_except = r_except;

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: vector table
// plus hand sequences, expected pcs via a scoreboard.
module tb_mips_fetch;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  control_type;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic [31:0] jr_data;
  logic        fetch_except;
  logic [31:0] inst_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_cnt;

  typedef struct {
    logic [31:0] set_pc;
    logic [1:0]  ct;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] jr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  mips_fetch #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .control_type (control_type),
    .imm16        (imm16),
    .jtarget      (jtarget),
    .jr_data      (jr_data),
    .fetch_except (fetch_except),
    .inst_count   (inst_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic junk_ctrl();
    control_type = 2'($urandom);
    imm16        = 16'($urandom);
    jtarget      = 26'($urandom);
    jr_data      = $urandom;
  endtask

  // Called at a negedge; returns one cycle after reset.
  task automatic do_reset();
    reset       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = $urandom;
    inst_ready  = 1'b1;
    junk_ctrl();
    @(negedge clk);
    reset       = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready  = 1'b0;
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_cnt", inst_count, 32'd0);
    chk("rst_exc", 32'(fetch_except), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_ipc", inst_pc, 32'd0);
    exp_q.delete();
    exp_q.push_back(RPC);
    model_cnt = '0;
  endtask

  // Entered at a negedge with the DUT in REQ.
  task automatic fetch_one(input logic [1:0]  ct,
                           input logic [15:0] imm,
                           input logic [25:0] jt,
                           input logic [31:0] jr,
                           input int lat,
                           input int hold,
                           input logic [31:0] nxt,
                           input bit halt);
    logic [31:0] a;
    logic [31:0] d;
    chk("req_hi", 32'(imem_req), 32'd1);
    chk("req_nv", 32'(inst_valid), 32'd0);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got none required 1");
      a = imem_addr;
    end else begin
      a = exp_q.pop_front();
      chk("imem_addr", imem_addr, a);
    end
    d = mem_word(a);
    for (int i = 0; i < lat; i++) begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      inst_ready  = 1'($urandom);
      junk_ctrl();
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, a);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    inst_ready  = 1'($urandom);
    junk_ctrl();
    @(negedge clk);
    chk("hold_valid", 32'(inst_valid), 32'd1);
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("inst", inst, d);
    chk("inst_pc", inst_pc, a);
    for (int i = 0; i < hold; i++) begin
      inst_ready  = 1'b0;
      imem_rvalid = 1'($urandom);
      imem_rdata  = $urandom;
      junk_ctrl();
      @(negedge clk);
      chk("stall_inst", inst, d);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_cnt", inst_count, model_cnt);
    end
    inst_ready   = 1'b1;
    imem_rvalid  = 1'($urandom);
    imem_rdata   = $urandom;
    control_type = ct;
    imm16        = imm;
    jtarget      = jt;
    jr_data      = (ct == 2'b11) ? jr : $urandom;
    model_cnt    = model_cnt + 32'd1;
    if (!halt) exp_q.push_back(nxt);
    @(negedge clk);
    inst_ready  = 1'b0;
    imem_rvalid = 1'b0;
    chk("inst_count", inst_count, model_cnt);
  endtask

  initial begin
    vecs[0] = '{32'h0040_0010, 2'b01, 16'hFFFE,
                26'h0, 32'h0, 32'h0040_000C};
    vecs[1] = '{32'h0040_0010, 2'b01, 16'h0003,
                26'h0, 32'h0, 32'h0040_0020};
    vecs[2] = '{32'h1040_0000, 2'b10, 16'h0,
                26'h000_0100, 32'h0, 32'h1000_0400};
    vecs[3] = '{32'h0040_0000, 2'b11, 16'h0,
                26'h0, 32'h0040_0100, 32'h0040_0100};
    vecs[4] = '{32'hFFFF_FFFC, 2'b00, 16'h0,
                26'h0, 32'h0, 32'h0000_0000};
    vecs[5] = '{32'h0040_0000, 2'b00, 16'h0,
                26'h0, 32'h0, 32'h0040_0004};
    vecs[6] = '{32'h0000_0004, 2'b01, 16'h8000,
                26'h0, 32'h0, 32'hFFFE_0008};
    vecs[7] = '{32'hF000_0000, 2'b10, 16'h0,
                26'h3FF_FFFF, 32'h0, 32'hFFFF_FFFC};

    reset       = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;
    model_cnt   = '0;
    junk_ctrl();
    repeat (2) @(negedge clk);
    do_reset();

    // Straight-line fetch at full rate.
    fetch_one(2'b00, 0, 0, 0, 0, 0, RPC + 32'd4, 0);
    fetch_one(2'b00, 0, 0, 0, 0, 0, RPC + 32'd8, 0);
    fetch_one(2'b00, 0, 0, 0, 0, 0, RPC + 32'd12, 0);
    chk("three_cnt", inst_count, 32'd3);

    // Slow memory and stalled decode.
    fetch_one(2'b00, 0, 0, 0, 3, 2, RPC + 32'd16, 0);

    foreach (vecs[k]) begin
      fetch_one(2'b11, 0, 0, vecs[k].set_pc,
                $urandom_range(0, 2), $urandom_range(0, 2),
                vecs[k].set_pc, 0);
      fetch_one(vecs[k].ct, vecs[k].imm, vecs[k].jt,
                vecs[k].jr, $urandom_range(0, 2),
                $urandom_range(0, 2), vecs[k].exp, 0);
    end

    // Misaligned jr halts until reset.
    fetch_one(2'b11, 0, 0, 32'h0040_0102, 1, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      chk("halt_exc", 32'(fetch_except), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_valid", 32'(inst_valid), 32'd0);
      chk("halt_cnt", inst_count, model_cnt);
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
      inst_ready  = 1'b1;
      junk_ctrl();
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    inst_ready  = 1'b0;
    do_reset();

    // Reset during a request with data arriving.
    fetch_one(2'b00, 0, 0, 0, 0, 1, RPC + 32'd4, 0);
    do_reset();
    fetch_one(2'b00, 0, 0, 0, 1, 0, RPC + 32'd4, 0);
    chk("post_rst_cnt", inst_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_fetch.md
MIPS_FETCH -- requirements
Module: mips_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00400000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request, held high until imem_rvalid.
REQ-005 imem_addr  output  32  byte address of requested instruction (equals pc).
REQ-006 imem_rvalid  input  1  read data valid this cycle; meaningful only while imem_req=1.
REQ-007 imem_rdata  input  32  instruction word returned with imem_rvalid.
REQ-008 inst  output  32  held instruction presented to decode stage.
REQ-009 inst_pc  output  32  address of inst.
REQ-010 inst_valid  output  1  inst/inst_pc valid for decode.
REQ-011 inst_ready  input  1  decode consumes inst this cycle; control inputs sampled when inst_valid & inst_ready.
REQ-012 control_type  input  2  00 fallthrough, 01 branch_target, 10 jump_target, 11 jump_register.
REQ-013 imm16  input  16  branch immediate field of inst.
REQ-014 jtarget  input  26  jump target field of inst.
REQ-015 jr_data  input  32  register value for jump_register.
REQ-016 fetch_except  output  1  sticky: jump_register target not word-aligned.
REQ-017 inst_count  output  32  number of instructions consumed since reset.

Function
REQ-018 States REQ, HOLD, HALT; exactly one active.
REQ-019 REQ: imem_req=1, imem_addr=pc, inst_valid=0; on imem_rvalid, inst<=imem_rdata, inst_pc<=pc, next state HOLD.
REQ-020 HOLD: imem_req=0, inst_valid=1, inst/inst_pc stable; stays HOLD while inst_ready=0.
REQ-021 HOLD with inst_ready=1: inst_count increments, pc<=next_pc, next state REQ (or HALT per REQ-024).
REQ-022 next_pc, pc4=pc+4: 00 -> pc4; 01 -> pc4 + (sign-extended imm16 << 2); 10 -> {pc4[31:28], jtarget, 2'b00}; 11 -> jr_data.
REQ-023 All address arithmetic modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0 with no flag.
REQ-024 control_type=11 with jr_data[1:0]!=0: instruction counted, pc unchanged, fetch_except<=1, next state HALT.
REQ-025 HALT: imem_req=0, inst_valid=0, inst_count frozen; left only by reset.
REQ-026 imem_rvalid outside REQ ignored; at most one request outstanding.
REQ-027 Minimum throughput: memory with same-cycle rvalid and inst_ready tied high yields one instruction per 2 cycles.
REQ-028 inst_count wraps 32'hFFFFFFFF -> 0.
REQ-029 control inputs ignored in any cycle without inst_valid & inst_ready.

Reset
REQ-030 reset=1 at a clock edge: state<=REQ, pc<=RESET_PC, inst<=0, inst_pc<=0, inst_count<=0, fetch_except<=0.
REQ-031 Reset overrides every other event in the same cycle, including imem_rvalid and inst_ready.
REQ-032 Reset mid-request abandons the request; next request is at RESET_PC; memory is reset by the same reset.
REQ-033 Outputs in the cycle after reset: imem_req=1, imem_addr=RESET_PC, inst_valid=0.

Structure
REQ-034 control_type encodings (00/01/10/11) and the RESET_PC default live in the shared opcode/constant definitions header used by mips_decode.
REQ-035 next_pc computation is one combinational sub-module, mips_next_pc (inputs pc, control_type, imm16, jtarget, jr_data; outputs next_pc, misaligned).
REQ-036 State register, pc, inst buffer and counter live in mips_fetch; no other sub-modules.

Verification
REQ-037 Reset, rvalid same cycle, inst_ready=1, control_type=00 -> imem_addr 0x00400000, 0x00400004, 0x00400008; inst_count=3 after third consume.
REQ-038 pc=0x00400010, control_type=01, imm16=16'hFFFE -> next imem_addr 0x0040000C; imm16=16'h0003 -> 0x00400020.
REQ-039 pc=0x1040_0000, control_type=10, jtarget=26'h0000100 -> next imem_addr 0x10000400.
REQ-040 control_type=11, jr_data=0x00400102 -> fetch_except=1, inst_valid=0, imem_req=0 permanently until reset; jr_data=0x00400100 -> imem_addr 0x00400100.
REQ-041 rvalid delayed 3 cycles, inst_ready low 2 cycles in HOLD -> imem_req held 4 cycles, inst stable, inst_count increments once.
REQ-042 reset asserted during REQ with rvalid same cycle -> data discarded, next imem_addr 0x00400000, inst_count=0.
